counter_ctrl: RTL and testbench
===============================

# counter_ctrl

Command-driven controller that sits on the driving side of the 8-bit-class up-counter. It accepts LOAD/RUN commands over a valid/ready port and sequences the counter's `enable`, `load` and `load_data` inputs. It observes the counter's `count` and `overflow` outputs, reports the final count per command and keeps a saturating overflow-event tally. It is the autonomous in-fabric replacement for the testbench driver, so system logic can program the counter without software intervention.

## Interface
- `WIDTH`, 8: counter width; must match the attached counter.
- `ARG_W`, 16: command argument width; `ARG_W >= WIDTH`.
- `EVT_W`, 16: overflow event counter width.

- `clk` in 1: single clock for the whole block.
- `rst_n` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: high only in IDLE.
- `cmd_op` in 2: 00 NOP, 01 LOAD, 10 RUN, 11 RUN_UNTIL_OVF.
- `cmd_arg` in ARG_W: LOAD value (low WIDTH bits), or run length / timeout.
- `ctr_enable` out 1: to counter `enable`.
- `ctr_load` out 1: to counter `load`.
- `ctr_load_data` out WIDTH: to counter `load_data`.
- `ctr_count` in WIDTH: from counter `count`.
- `ctr_overflow` in 1: from counter `overflow`.
- `busy` out 1: state != IDLE.
- `done` out 1: one-cycle pulse at command completion.
- `rsp_count` out WIDTH: `ctr_count` sampled at completion.
- `rsp_ovf` out 1: an overflow was seen during the completed command.
- `ovf_clr` in 1: synchronous clear of `ovf_events`.
- `ovf_events` out EVT_W: saturating count of `ctr_overflow` pulses.

## Operation
- Attached counter contract:
  - `load` has priority over `enable`; otherwise `enable` increments by 1.
  - `overflow` is a registered one-cycle pulse, coincident with count wrapping `'1`→0.
- FSM states: IDLE, LOAD, RUN, SETTLE. `ctr_enable`, `ctr_load` and `ctr_load_data` are registered Moore outputs.
- IDLE: on `cmd_valid && cmd_ready`, latch op and arg, clear the per-command overflow flag, then:
  - LOAD → LOAD.
  - RUN with arg=0 → SETTLE.
  - RUN or RUN_UNTIL_OVF with arg≠0 → RUN.
  - RUN_UNTIL_OVF with arg=0 → RUN; arg=0 means no timeout.
  - NOP → accepted, no state change, no `done`.
- LOAD (1 cycle): `ctr_load`=1, `ctr_load_data`=arg[WIDTH-1:0]. Then → SETTLE.
- RUN: `ctr_enable`=1. A remaining-cycle counter, loaded with arg, decrements each RUN cycle.
  - RUN op: → SETTLE after exactly arg RUN cycles.
  - RUN_UNTIL_OVF: → SETTLE after the cycle in which `ctr_count=='1` (enable high, so the wrap occurs), or on timeout, whichever is first. When both occur in the same cycle, the result is the same transition.
- SETTLE (1 cycle): all counter drives low. At the exiting edge: `rsp_count<=ctr_count`, `rsp_ovf<=flag|ctr_overflow`, `done<=1`, → IDLE.
- Overflow handling:
  - The per-command flag sets on `ctr_overflow` in RUN or SETTLE.
  - `ovf_events` increments on every `ctr_overflow` cycle in any state and saturates at all-ones.
  - `ovf_clr` wins over a same-cycle increment.
- Invalid combinations are impossible: all 2-bit opcodes are defined.

## Timing
- All register outputs reset to 0: `ctr_*`, `busy`, `done`, `rsp_*`, `ovf_events`.
- State resets to IDLE. `cmd_ready` (= IDLE) reads 1 immediately after reset release.
- Accept edge = E0; cycles numbered after E0:
  - LOAD: `ctr_load` in cycle 1, SETTLE cycle 2, `done` cycle 3.
  - RUN n (n≥1): `ctr_enable` cycles 1..n, SETTLE n+1, `done` n+2.
  - RUN 0: SETTLE cycle 1, `done` cycle 2.
- `done` coincides with `cmd_ready`=1. A new command is acceptable in the `done` cycle; back-to-back throughput is one command per (latency) cycles.
- Reset mid-command:
  - All outputs drop asynchronously.
  - The in-flight command is discarded with no `done`.
  - `ovf_events` is cleared.

## Structure
- `counter_ctrl_pkg`: `op_e` enum (NOP/LOAD/RUN/RUN_UNTIL_OVF) and `state_e` enum.
- One natural sub-module: `sat_counter` (EVT_W, inc, clr, saturating) for `ovf_events`.
- The remaining-cycle counter and FSM stay inline.

## Test plan
- WIDTH=8. LOAD 0x5A → `ctr_load`=1 with `load_data`=0x5A in cycle 1; `done` in cycle 3; `rsp_count`=0x5A, `rsp_ovf`=0.
- LOAD 0xFD, then RUN 5 → `ctr_enable` high for exactly 5 cycles; `rsp_count`=0x02, `rsp_ovf`=1, `ovf_events`=1.
- RUN 0 → no `ctr_enable` pulse; `done` in cycle 2; `rsp_count` unchanged.
- LOAD 0xF0, then RUN_UNTIL_OVF arg=0 → 16 enable cycles; `rsp_count`=0x00, `rsp_ovf`=1.
- LOAD 0x00, then RUN_UNTIL_OVF arg=10 → timeout after 10 enable cycles; `rsp_count`=0x0A, `rsp_ovf`=0.
- Assert `rst_n` low in cycle 3 of RUN 8 → `ctr_enable`, `busy` and `ovf_events` go to 0 immediately with no `done`. Separately, with EVT_W=2, 4 overflows → `ovf_events`=3 (saturated), and `ovf_clr` coincident with an overflow → 0.

Source files
------------

// File: rtl/counter_ctrl_pkg.sv
// counter_ctrl_pkg
//   Shared types for the counter command controller.
//   op_e    : command opcodes carried on cmd_op.
//   state_e : controller FSM states.
package counter_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_NOP           = 2'b00,
        OP_LOAD          = 2'b01,
        OP_RUN           = 2'b10,
        OP_RUN_UNTIL_OVF = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_LOAD   = 2'b01,
        ST_RUN    = 2'b10,
        ST_SETTLE = 2'b11
    } state_e;

endpackage

// File: rtl/sat_counter.sv
// sat_counter
//   Saturating event counter with synchronous clear.
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset
//     inc        : count one event this cycle
//     clr        : synchronous clear; wins over a same-cycle inc
//     value      : current count, sticks at all-ones
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] value
);

    localparam logic [W-1:0] ONE = 1;

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= '0;
        end else if (clr) begin
            value <= '0;
        end else if (inc && (value != '1)) begin
            value <= value + ONE;
        end
    end

endmodule

// File: rtl/counter_ctrl.sv
// counter_ctrl
//   Command-driven sequencer for an attached up-counter. Accepts
//   LOAD / RUN / RUN_UNTIL_OVF commands over a valid/ready port, drives the
//   counter's enable/load/load_data, and reports the final count per
//   command plus a saturating tally of counter overflow pulses.
//   Ports:
//     clk, rst_n                 : clock, asynchronous active-low reset
//     cmd_valid/cmd_ready        : command handshake (ready only in IDLE)
//     cmd_op, cmd_arg            : opcode and argument (load value / length)
//     ctr_enable, ctr_load,
//     ctr_load_data              : registered drives to the counter
//     ctr_count, ctr_overflow    : observed counter outputs
//     busy                       : a command is in flight
//     done                       : one-cycle completion pulse
//     rsp_count, rsp_ovf         : final count / overflow seen, per command
//     ovf_clr, ovf_events        : clear and value of the overflow tally
module counter_ctrl
    import counter_ctrl_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int ARG_W = 16,
    parameter int EVT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [ARG_W-1:0] cmd_arg,
    output logic             ctr_enable,
    output logic             ctr_load,
    output logic [WIDTH-1:0] ctr_load_data,
    input  logic [WIDTH-1:0] ctr_count,
    input  logic             ctr_overflow,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] rsp_count,
    output logic             rsp_ovf,
    input  logic             ovf_clr,
    output logic [EVT_W-1:0] ovf_events
);

    localparam logic [ARG_W-1:0] ARG_ONE = 1;

    state_e           state_q, state_d;
    logic [ARG_W-1:0] rem_q;      // RUN cycles left, including the current one
    logic             timed_q;    // remaining-cycle limit is active
    logic             until_q;    // command also ends on counter wrap
    logic             flag_q;     // overflow seen during this command
    logic             accept;

    assign cmd_ready = (state_q == ST_IDLE);

    // NOTE: every signal written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    accept = 1'b1;
                    case (op_e'(cmd_op))
                        OP_LOAD:          state_d = ST_LOAD;
                        OP_RUN:           state_d = (cmd_arg == '0) ? ST_SETTLE : ST_RUN;
                        OP_RUN_UNTIL_OVF: state_d = ST_RUN;
                        default:          state_d = ST_IDLE;  // NOP
                    endcase
                end
            end
            ST_LOAD: state_d = ST_SETTLE;
            ST_RUN: begin
                // Leaving on ctr_count == '1 lets the wrap happen on this
                // edge, since enable is high for the whole RUN cycle.
                if ((timed_q && (rem_q == ARG_ONE)) ||
                    (until_q && (ctr_count == '1))) begin
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            rem_q         <= '0;
            timed_q       <= 1'b0;
            until_q       <= 1'b0;
            flag_q        <= 1'b0;
            ctr_enable    <= 1'b0;
            ctr_load      <= 1'b0;
            ctr_load_data <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            rsp_count     <= '0;
            rsp_ovf       <= 1'b0;
        end else begin
            state_q <= state_d;

            // Moore drives registered from the next state so they line up
            // with the cycle the FSM spends in that state.
            ctr_enable    <= (state_d == ST_RUN);
            ctr_load      <= (state_d == ST_LOAD);
            ctr_load_data <= (state_d == ST_LOAD) ? cmd_arg[WIDTH-1:0] : '0;
            busy          <= (state_d != ST_IDLE);
            done          <= (state_q == ST_SETTLE);

            if (accept) begin
                rem_q   <= cmd_arg;
                timed_q <= (cmd_arg != '0);
                until_q <= (op_e'(cmd_op) == OP_RUN_UNTIL_OVF);
                flag_q  <= 1'b0;
            end else begin
                if (state_q == ST_RUN) begin
                    rem_q <= rem_q - ARG_ONE;
                end
                if (ctr_overflow && ((state_q == ST_RUN) || (state_q == ST_SETTLE))) begin
                    flag_q <= 1'b1;
                end
            end

            if (state_q == ST_SETTLE) begin
                rsp_count <= ctr_count;
                rsp_ovf   <= flag_q | ctr_overflow;
            end
        end
    end

    sat_counter #(.W(EVT_W)) u_ovf_events (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (ctr_overflow),
        .clr   (ovf_clr),
        .value (ovf_events)
    );

endmodule

// File: tb/tb_counter_ctrl.sv
// tb_counter_ctrl
//   Self-checking bench for counter_ctrl. Contains a behavioural model of
//   the attached 8-bit counter, an arithmetic reference for each command's
//   outcome, and a second instance with a 2-bit event tally for saturation.
module tb_counter_ctrl;
    import counter_ctrl_pkg::*;

    localparam int WIDTH = 8;
    localparam int ARG_W = 16;
    localparam int EVT_W = 16;
    localparam longint EVT_MAX = 65535;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [1:0]       cmd_op = 2'b00;
    logic [ARG_W-1:0] cmd_arg = '0;
    logic             ctr_enable, ctr_load;
    logic [WIDTH-1:0] ctr_load_data;
    logic [WIDTH-1:0] cnt;
    logic             ovf;
    logic             busy, done;
    logic [WIDTH-1:0] rsp_count;
    logic             rsp_ovf;
    logic             ovf_clr = 1'b0;
    logic [EVT_W-1:0] ovf_events;

    // second instance: overflow pulses driven directly by the bench
    logic             ovf2 = 1'b0;
    logic             clr2 = 1'b0;
    logic [1:0]       ev2;
    logic             rdy2, en2, ld2, busy2, done2, rovf2;
    logic [WIDTH-1:0] ldd2, rcnt2;
    logic [WIDTH-1:0] cnt2 = '0;

    int n_tests = 0;
    int n_fail  = 0;
    int m_count = 0;      // model: counter value
    longint m_events = 0; // model: overflow tally

    always #5 clk = ~clk;

    // Attached counter: load beats enable; overflow pulses as it wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            ovf <= 1'b0;
        end else if (ctr_load) begin
            cnt <= ctr_load_data;
            ovf <= 1'b0;
        end else if (ctr_enable) begin
            cnt <= cnt + 8'd1;
            ovf <= (cnt == 8'hFF);
        end else begin
            ovf <= 1'b0;
        end
    end

    counter_ctrl #(.WIDTH(WIDTH), .ARG_W(ARG_W), .EVT_W(EVT_W)) u_dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_arg(cmd_arg), .ctr_enable(ctr_enable),
        .ctr_load(ctr_load), .ctr_load_data(ctr_load_data), .ctr_count(cnt),
        .ctr_overflow(ovf), .busy(busy), .done(done), .rsp_count(rsp_count),
        .rsp_ovf(rsp_ovf), .ovf_clr(ovf_clr), .ovf_events(ovf_events)
    );

    counter_ctrl #(.WIDTH(WIDTH), .ARG_W(ARG_W), .EVT_W(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(1'b0), .cmd_ready(rdy2),
        .cmd_op(2'b00), .cmd_arg(16'h0000), .ctr_enable(en2),
        .ctr_load(ld2), .ctr_load_data(ldd2), .ctr_count(cnt2),
        .ctr_overflow(ovf2), .busy(busy2), .done(done2), .rsp_count(rcnt2),
        .rsp_ovf(rovf2), .ovf_clr(clr2), .ovf_events(ev2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic void add_events(input int n);
        m_events = m_events + n;
        if (m_events > EVT_MAX) m_events = EVT_MAX;
    endfunction

    // Issue one command and check its whole outcome against the model.
    // Called and returns near a falling edge.
    task automatic do_cmd(input logic [1:0] op, input logic [ARG_W-1:0] arg);
        int k, exp_lat, exp_en, exp_ld, exp_cnt, exp_ovf, wraps;
        int lat, en_seen, ld_seen, guard;
        logic [7:0] arg_lo;
        arg_lo  = arg[7:0];
        exp_ld  = 0;
        exp_en  = 0;
        exp_lat = 0;
        exp_cnt = m_count;
        exp_ovf = 0;
        wraps   = 0;
        case (op)
            OP_LOAD: begin
                exp_lat = 3; exp_ld = 1; exp_cnt = int'(arg_lo);
            end
            OP_RUN: begin
                k = int'(arg);
                exp_en = k; exp_lat = k + 2;
                wraps = (m_count + k) / 256;
                exp_cnt = (m_count + k) % 256;
                exp_ovf = (wraps > 0) ? 1 : 0;
            end
            OP_RUN_UNTIL_OVF: begin
                k = 256 - m_count;
                if ((arg != 0) && (int'(arg) < k)) k = int'(arg);
                exp_en = k; exp_lat = k + 2;
                wraps = (m_count + k) / 256;
                exp_cnt = (m_count + k) % 256;
                exp_ovf = (wraps > 0) ? 1 : 0;
            end
            default: ;
        endcase

        guard = 0;
        while (!cmd_ready && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        check("cmd_ready_before_issue", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_arg   = arg;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_op    = 2'($urandom);
        cmd_arg   = 16'($urandom);

        if (op == OP_NOP) begin
            for (int c = 1; c <= 3; c++) begin
                @(negedge clk);
                check("nop_done", done, 0);
                check("nop_busy", busy, 0);
            end
            return;
        end

        lat = 0; en_seen = 0; ld_seen = 0;
        for (int c = 1; c <= 2000; c++) begin
            @(negedge clk);
            if (done) begin
                lat = c;
                break;
            end
            if (ctr_enable) en_seen++;
            if (ctr_load) ld_seen++;
            if (c == 1 && op == OP_LOAD) begin
                check("load_pulse_c1", ctr_load, 1);
                check("load_data_c1", ctr_load_data, arg_lo);
            end
        end
        check("done_latency", lat, exp_lat);
        check("enable_cycles", en_seen, exp_en);
        check("load_cycles", ld_seen, exp_ld);
        check("ready_with_done", cmd_ready, 1);
        check("rsp_count", rsp_count, exp_cnt);
        check("rsp_ovf", rsp_ovf, exp_ovf);
        m_count = exp_cnt;
        add_events(wraps);
        check("ovf_events", ovf_events, 32'(m_events));
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int done_seen, n2, op_r;
        logic [ARG_W-1:0] arg_r;

        // ---- reset values ----
        repeat (3) @(negedge clk);
        check("rst_enable", ctr_enable, 0);
        check("rst_load", ctr_load, 0);
        check("rst_load_data", ctr_load_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rsp_count", rsp_count, 0);
        check("rst_rsp_ovf", rsp_ovf, 0);
        check("rst_ovf_events", ovf_events, 0);
        rst_n = 1'b1;
        #1;
        check("ready_after_reset", cmd_ready, 1);
        @(negedge clk);

        // ---- directed commands ----
        do_cmd(OP_LOAD, 16'h005A);
        do_cmd(OP_LOAD, 16'h00FD);
        do_cmd(OP_RUN, 16'd5);
        do_cmd(OP_RUN, 16'd0);
        do_cmd(OP_NOP, 16'd7);
        do_cmd(OP_LOAD, 16'h00F0);
        do_cmd(OP_RUN_UNTIL_OVF, 16'd0);
        do_cmd(OP_LOAD, 16'h0000);
        do_cmd(OP_RUN_UNTIL_OVF, 16'd10);
        do_cmd(OP_LOAD, 16'hAB80);
        do_cmd(OP_RUN, 16'd300);

        // ---- tally clear ----
        ovf_clr = 1'b1;
        @(posedge clk);
        #1;
        ovf_clr = 1'b0;
        m_events = 0;
        check("ovf_clr", ovf_events, 32'(m_events));
        @(negedge clk);

        // ---- reset in the middle of RUN 8 ----
        do_cmd(OP_RUN_UNTIL_OVF, 16'd0);   // leaves one event in the tally
        cmd_valid = 1'b1;
        cmd_op    = OP_RUN;
        cmd_arg   = 16'd8;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_enable_before", ctr_enable, 1);
        check("mid_busy_before", busy, 1);
        check("mid_events_before", ovf_events, 32'(m_events));
        rst_n = 1'b0;
        #1;
        m_count = 0;
        m_events = 0;
        check("mid_enable_async", ctr_enable, 0);
        check("mid_busy_async", busy, 0);
        check("mid_events_async", ovf_events, 32'(m_events));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        done_seen = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done || busy || ctr_enable) done_seen++;
        end
        check("mid_no_done_after", done_seen, 0);

        // ---- randomized commands ----
        for (int i = 0; i < 25; i++) begin
            op_r = int'($urandom_range(0, 3));
            case (op_r)
                1:       arg_r = 16'($urandom);
                2:       arg_r = 16'($urandom_range(0, 300));
                3:       arg_r = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(1, 300));
                default: arg_r = 16'($urandom);
            endcase
            do_cmd(2'(op_r), arg_r);
        end

        // ---- 2-bit tally saturation and clear priority ----
        n2 = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            ovf2 = 1'b1;
            @(negedge clk);
            ovf2 = 1'b0;
            n2++;
            if (i == 0) check("sat_one", ev2, 32'(n2));
        end
        check("sat_saturated", ev2, (n2 > 3) ? 3 : n2);
        @(negedge clk);
        ovf2 = 1'b1;
        clr2 = 1'b1;
        @(negedge clk);
        ovf2 = 1'b0;
        clr2 = 1'b0;
        n2 = 0;
        check("sat_clr_wins", ev2, 32'(n2));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
